// File: rtl/adxl362_pkg.sv
// Shared types and sizes for the ADXL362 FIFO read path.
package adxl362_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HIGH  = 2'd2
    } rd_state_t;

    localparam int FIFO_DEPTH   = 512;
    localparam int FIFO_LEVEL_W = 10;
    localparam int WM_W         = 9;

endpackage

// File: rtl/adxl362_fifo_read_ctrl.sv
// Serves FIFO words to the SPI slave a byte at a time (low byte first), with watermark and underrun flags.
// Build option: define ADXL362_FIFO_TAG_EN to pass the axis tag through in the high byte.
module adxl362_fifo_read_ctrl
    import adxl362_pkg::*;
(
    input  logic                    clk_16mhz,
    input  logic                    reset,
    input  logic                    byte_req,
    input  logic                    cs_end,
    input  logic                    fifo_empty,
    input  logic [15:0]             fifo_data,
    input  logic [FIFO_LEVEL_W-1:0] fifo_level,
    input  logic                    fifo_ah,
    input  logic [7:0]              fifo_samples,
    input  logic                    clear_status,
    output logic                    fifo_pop,
    output logic [7:0]              byte_data,
    output logic                    byte_valid,
    output logic                    watermark,
    output logic                    underrun
);

    rd_state_t       state_reg, state_next;
    logic [15:0]     word_reg, word_next;
    logic [7:0]      byte_data_reg, byte_data_next;
    logic            byte_valid_reg, byte_valid_next;
    logic            watermark_reg, watermark_next;
    logic            underrun_reg, underrun_next;
    logic            pop_req;
    logic            empty_read;
    logic [WM_W-1:0] wm_threshold;

    function automatic logic [7:0] high_byte(input logic [15:0] word);
`ifdef ADXL362_FIFO_TAG_EN
        return word[15:8];
`else
        // Tag bits are replaced by the sign of the 14-bit sample.
        return {word[13], word[13], word[13:8]};
`endif
    endfunction

    assign wm_threshold = {fifo_ah, fifo_samples};

    always_comb begin
        state_next      = state_reg;
        word_next       = word_reg;
        byte_data_next  = byte_data_reg;
        byte_valid_next = 1'b0;
        underrun_next   = underrun_reg;
        pop_req         = 1'b0;
        empty_read      = 1'b0;

        if (cs_end) begin
            // End of transaction drops any held or in-flight word.
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (byte_req) begin
                        if (!fifo_empty) begin
                            pop_req    = 1'b1;
                            state_next = ST_FETCH;
                        end else begin
                            byte_data_next  = 8'h00;
                            byte_valid_next = 1'b1;
                            empty_read      = 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    word_next       = fifo_data;
                    byte_data_next  = fifo_data[7:0];
                    byte_valid_next = 1'b1;
                    state_next      = ST_HIGH;
                end
                ST_HIGH: begin
                    if (byte_req) begin
                        byte_data_next  = high_byte(word_reg);
                        byte_valid_next = 1'b1;
                        state_next      = ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end

        // A new underrun beats a simultaneous clear.
        if (empty_read) begin
            underrun_next = 1'b1;
        end else if (clear_status) begin
            underrun_next = 1'b0;
        end

        watermark_next = (wm_threshold != '0)
                      && (FIFO_LEVEL_W'(wm_threshold) <= FIFO_LEVEL_W'(FIFO_DEPTH))
                      && (fifo_level >= FIFO_LEVEL_W'(wm_threshold));
    end

    always_ff @(posedge clk_16mhz) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            word_reg       <= 16'h0000;
            byte_data_reg  <= 8'h00;
            byte_valid_reg <= 1'b0;
            watermark_reg  <= 1'b0;
            underrun_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            word_reg       <= word_next;
            byte_data_reg  <= byte_data_next;
            byte_valid_reg <= byte_valid_next;
            watermark_reg  <= watermark_next;
            underrun_reg   <= underrun_next;
        end
    end

    assign fifo_pop   = pop_req && !reset;
    assign byte_data  = byte_data_reg;
    assign byte_valid = byte_valid_reg;
    assign watermark  = watermark_reg;
    assign underrun   = underrun_reg;

endmodule

// File: tb/tb_adxl362_fifo_read_ctrl.sv
// Self-checking bench for adxl362_fifo_read_ctrl: directed scenarios, watermark table, randomized byte stream.
module tb_adxl362_fifo_read_ctrl;

    logic        clk_16mhz = 1'b0;
    logic        reset;
    logic        byte_req;
    logic        cs_end;
    logic        fifo_empty;
    logic [15:0] fifo_data;
    logic [9:0]  fifo_level;
    logic        fifo_ah;
    logic [7:0]  fifo_samples;
    logic        clear_status;
    logic        fifo_pop;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        watermark;
    logic        underrun;

    adxl362_fifo_read_ctrl dut (
        .clk_16mhz    (clk_16mhz),
        .reset        (reset),
        .byte_req     (byte_req),
        .cs_end       (cs_end),
        .fifo_empty   (fifo_empty),
        .fifo_data    (fifo_data),
        .fifo_level   (fifo_level),
        .fifo_ah      (fifo_ah),
        .fifo_samples (fifo_samples),
        .clear_status (clear_status),
        .fifo_pop     (fifo_pop),
        .byte_data    (byte_data),
        .byte_valid   (byte_valid),
        .watermark    (watermark),
        .underrun     (underrun)
    );

    always #5 clk_16mhz = ~clk_16mhz;

    typedef struct {
        int         level;
        logic       ah;
        logic [7:0] samples;
        logic       exp_wm;
    } wm_vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] fifo_q[$];
    logic        pop_seen = 1'b0;
    logic        prev_pop = 1'b0;
    bit          auto_level = 1'b1;
    wm_vec_t     tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic wm_model(input int level, input int thr);
        return (thr > 0) && (level >= thr);
    endfunction

    // Expected high byte computed arithmetically from the word value.
    function automatic logic [7:0] exp_high(input logic [15:0] w);
        logic [31:0] u;
        int v;
`ifdef ADXL362_FIFO_TAG_EN
        v = int'(w) / 256;
`else
        v = int'(w & 16'h3FFF);
        if (v >= 8192) v = v - 16384;
        v = v >>> 8;
`endif
        u = v;
        return u[7:0];
    endfunction

    task automatic sync_fifo();
        fifo_empty = (fifo_q.size() == 0);
        fifo_level = 10'(fifo_q.size());
    endtask

    task automatic push_word(input logic [15:0] w);
        fifo_q.push_back(w);
        if (auto_level) sync_fifo();
    endtask

    // One clock: called at negedge with inputs set, returns at the next negedge.
    task automatic cycle();
        logic wm_exp;
        #1;
        pop_seen = fifo_pop;
        if (pop_seen) begin
            chk("pop_while_empty", 32'(fifo_empty), 0);
            chk("pop_back_to_back", 32'(prev_pop), 0);
        end
        wm_exp = reset ? 1'b0 : wm_model(int'(fifo_level), int'({fifo_ah, fifo_samples}));
        @(posedge clk_16mhz);
        #1;
        prev_pop = pop_seen;
        if (pop_seen && fifo_q.size() > 0) fifo_data = fifo_q.pop_front();
        byte_req     = 1'b0;
        cs_end       = 1'b0;
        clear_status = 1'b0;
        if (auto_level) sync_fifo();
        @(negedge clk_16mhz);
        chk("watermark", 32'(watermark), 32'(wm_exp));
    endtask

    task automatic read_pair(input logic [15:0] w, input logic [7:0] hi, input int gap);
        push_word(w);
        byte_req = 1'b1;
        cycle();
        chk("low_pop", 32'(pop_seen), 1);
        chk("low_not_yet", 32'(byte_valid), 0);
        cycle();
        chk("low_valid", 32'(byte_valid), 1);
        chk("low_data", 32'(byte_data), 32'(w[7:0]));
        for (int i = 0; i < gap; i++) begin
            cycle();
            chk("gap_no_valid", 32'(byte_valid), 0);
            chk("gap_hold", 32'(byte_data), 32'(w[7:0]));
        end
        byte_req = 1'b1;
        cycle();
        chk("high_no_pop", 32'(pop_seen), 0);
        chk("high_valid", 32'(byte_valid), 1);
        chk("high_data", 32'(byte_data), 32'(hi));
        $display("read word 0x%04h -> lo 0x%02h hi 0x%02h", w, w[7:0], byte_data);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] mq[$];
        logic [15:0] pend_w;
        logic [15:0] w;
        logic [7:0]  exp_b;
        bit          pend;
        bit          m_underrun;
        int          lat, gap, r;
        logic        prev_exp;

        tbl[0] = '{15,  1'b0, 8'h10, 1'b0};
        tbl[1] = '{16,  1'b0, 8'h10, 1'b1};
        tbl[2] = '{17,  1'b0, 8'h10, 1'b1};
        tbl[3] = '{300, 1'b0, 8'h00, 1'b0};
        tbl[4] = '{512, 1'b1, 8'h00, 1'b1};
        tbl[5] = '{255, 1'b1, 8'h00, 1'b0};
        tbl[6] = '{512, 1'b1, 8'hFF, 1'b1};
        tbl[7] = '{510, 1'b1, 8'hFF, 1'b0};
        tbl[8] = '{0,   1'b0, 8'h01, 1'b0};
        tbl[9] = '{1,   1'b0, 8'h01, 1'b1};

        reset = 1'b1;
        byte_req = 1'b0; cs_end = 1'b0; clear_status = 1'b0;
        fifo_data = 16'h0000; fifo_ah = 1'b0; fifo_samples = 8'h00;
        sync_fifo();
        @(negedge clk_16mhz);
        cycle();
        cycle();
        chk("rst_pop", 32'(pop_seen), 0);
        chk("rst_valid", 32'(byte_valid), 0);
        chk("rst_data", 32'(byte_data), 0);
        chk("rst_underrun", 32'(underrun), 0);
        reset = 1'b0;
        cycle();

        // Low byte two cycles after the request, high byte one cycle after.
`ifdef ADXL362_FIFO_TAG_EN
        read_pair(16'h1A5C, 8'h1A, 8);
        read_pair(16'h2A5C, 8'h2A, 8);
`else
        read_pair(16'h1A5C, 8'h1A, 8);
        read_pair(16'h2A5C, 8'hEA, 8);
`endif

        // Empty read and sticky underrun.
        byte_req = 1'b1;
        cycle();
        chk("empty_no_pop", 32'(pop_seen), 0);
        chk("empty_valid", 32'(byte_valid), 1);
        chk("empty_data", 32'(byte_data), 0);
        chk("empty_underrun", 32'(underrun), 1);
        clear_status = 1'b1;
        cycle();
        chk("clear_underrun", 32'(underrun), 0);
        clear_status = 1'b1;
        byte_req = 1'b1;
        cycle();
        chk("set_beats_clear", 32'(underrun), 1);
        chk("set_clear_valid", 32'(byte_valid), 1);
        $display("empty read: byte 0x%02h underrun %0d", byte_data, underrun);

        // Watermark table: each result checked one cycle after the inputs change.
        auto_level = 1'b0;
        prev_exp = 1'b0;
        foreach (tbl[i]) begin
            fifo_level   = 10'(tbl[i].level);
            fifo_ah      = tbl[i].ah;
            fifo_samples = tbl[i].samples;
            #1;
            chk("wm_latency", 32'(watermark), 32'(prev_exp));
            cycle();
            chk("wm_table", 32'(watermark), 32'(tbl[i].exp_wm));
            $display("wm level %0d thr %0d -> %0d", tbl[i].level, {tbl[i].ah, tbl[i].samples}, watermark);
            prev_exp = tbl[i].exp_wm;
        end
        auto_level = 1'b1;
        sync_fifo();
        fifo_ah = 1'b0;
        fifo_samples = 8'h01;
        cycle();

        // cs_end while a high byte is held.
        push_word(16'h3C81);
        push_word(16'h0247);
        byte_req = 1'b1;
        cycle();
        cycle();
        chk("cs_low_data", 32'(byte_data), 'h81);
        cycle();
        cs_end = 1'b1;
        cycle();
        chk("cs_no_valid", 32'(byte_valid), 0);
        byte_req = 1'b1;
        cycle();
        chk("cs_new_pop", 32'(pop_seen), 1);
        chk("cs_no_stale", 32'(byte_valid), 0);
        cycle();
        chk("cs_next_valid", 32'(byte_valid), 1);
        chk("cs_next_low", 32'(byte_data), 'h47);
        cs_end = 1'b1;
        byte_req = 1'b1;
        cycle();
        chk("cs_beats_req", 32'(byte_valid), 0);
        $display("cs_end in HIGH: next byte 0x47 checked");

        // Reset while in FETCH.
        push_word(16'h7E55);
        cycle();
        byte_req = 1'b1;
        cycle();
        chk("rf_pop", 32'(pop_seen), 1);
        reset = 1'b1;
        cycle();
        chk("rf_no_pop", 32'(pop_seen), 0);
        chk("rf_valid", 32'(byte_valid), 0);
        chk("rf_data", 32'(byte_data), 0);
        chk("rf_underrun", 32'(underrun), 0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("rf_no_valid_after", 32'(byte_valid), 0);
        end
        $display("reset in FETCH: outputs cleared");

        // Randomized byte stream against a word-level model.
        pend = 1'b0;
        m_underrun = 1'b0;
        for (int n = 0; n < 250; n++) begin
            r = $urandom_range(0, 9);
            if (r < 3) begin
                w = 16'($urandom);
                mq.push_back(w);
                push_word(w);
                fifo_samples = 8'($urandom_range(0, 3));
                cycle();
            end else if (r == 3) begin
                cs_end = 1'b1;
                pend = 1'b0;
                cycle();
                chk("rnd_cs_no_valid", 32'(byte_valid), 0);
            end else if (r == 4) begin
                clear_status = 1'b1;
                m_underrun = 1'b0;
                cycle();
                chk("rnd_clear", 32'(underrun), 0);
            end else begin
                if (pend) begin
                    exp_b = exp_high(pend_w);
                    lat = 1;
                    pend = 1'b0;
                end else if (mq.size() == 0) begin
                    exp_b = 8'h00;
                    lat = 1;
                    m_underrun = 1'b1;
                end else begin
                    pend_w = mq.pop_front();
                    exp_b = pend_w[7:0];
                    lat = 2;
                    pend = 1'b1;
                end
                byte_req = 1'b1;
                gap = $urandom_range(3, 6);
                for (int i = 1; i <= gap; i++) begin
                    cycle();
                    if (i == lat) begin
                        chk("rnd_valid", 32'(byte_valid), 1);
                        chk("rnd_data", 32'(byte_data), 32'(exp_b));
                    end else begin
                        chk("rnd_idle", 32'(byte_valid), 0);
                    end
                end
                chk("rnd_underrun", 32'(underrun), 32'(m_underrun));
                $display("rnd req %0d: byte 0x%02h expected 0x%02h underrun %0d", n, byte_data, exp_b, underrun);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
